rs_encoder_stream: RTL
======================

// Module: rs_encoder_stream
// PURPOSE
//  Streaming systematic Reed-Solomon encoder over GF(2^SYM_W): one symbol per beat, LFSR division by g(x).
//  Passes message symbols through, then appends N_PAR parity symbols, highest degree first.
//  Successor to the block-parallel encoder: parametric code, valid/ready both sides, shortened codewords.
//  Sits between framer and line interface of the FEC transmit path.
// PARAMETERS
//  SYM_W   8      symbol width (bits); field GF(2^SYM_W)
//  PRIM    8'h1d  primitive polynomial, low SYM_W bits (x^SYM_W term implicit)
//  K_MAX   64     maximum message symbols per codeword; K_MAX + N_PAR <= 2^SYM_W - 1
//  N_PAR   4      parity symbols (2t); >= 2, even
//  FCR     0      first consecutive root: g(x) = prod_{i=0..N_PAR-1} (x + a^(FCR+i)), a = 2
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  s_data       in   SYM_W  message symbol
//  s_valid      in   1      s_data valid
//  s_ready      out  1      encoder accepts s_data
//  s_last       in   1      last message symbol of codeword (shortened code when count < K_MAX)
//  m_data       out  SYM_W  codeword symbol
//  m_valid      out  1      m_data valid
//  m_ready      in   1      downstream accepts m_data
//  m_last       out  1      last parity symbol of codeword
//  m_parity     out  1      m_data is a parity symbol
//  len_err      out  1      1-cycle pulse: K_MAX symbols accepted without s_last
// BEHAVIOUR
//  One clock, one reset; rst has priority over everything. On rst: state MSG, LFSR r[0..N_PAR-1]=0,
//   symbol count=0, parity index=0, m_valid=0, m_data=0, m_last=0, m_parity=0, len_err=0.
//  Reset mid-codeword discards the partial codeword; no parity for it is ever emitted.
//  g(x) coefficients g[0..N_PAR-1] computed at elaboration by constant function; no tables in RTL.
//  Output is a single register stage: load allowed when !m_valid || m_ready.
//  State MSG: s_ready = !m_valid || m_ready. On accept (s_valid && s_ready):
//   - m_data<=s_data, m_valid<=1, m_parity<=0, m_last<=0; count++
//   - fb = s_data ^ r[N_PAR-1]; r[i] <= r[i-1] ^ g[i]*fb (r[-1]=0), GF mult reduced by PRIM
//   - if s_last or count == K_MAX-1 -> state PAR, idx=0; len_err pulses if count==K_MAX-1 && !s_last
//     (s_last on symbol K_MAX is legal, no error)
//  State PAR: s_ready=0. When output register free: m_data<=r[N_PAR-1], shift r up (r[i]<=r[i-1],
//   r[0]<=0), m_parity<=1, idx++; on idx==N_PAR-1 also m_last<=1, count<=0, state->MSG.
//   After the last parity beat the LFSR is all-zero, ready for the next codeword with no extra clear.
//  No bubbles: with s_valid and m_ready held high, throughput is one symbol per cycle;
//   codeword of K symbols occupies K+N_PAR output beats; latency s_data -> m_data = 1 cycle.
//  m_data/m_last/m_parity hold stable while m_valid && !m_ready (AXI-stream rules).
//  s_valid while in PAR is stalled, not dropped; s_last on an unaccepted beat has no effect.
//  Empty codeword impossible: s_last is only sampled with an accepted symbol.
// TESTING
//  Defaults (g = x^4+15x^3+54x^2+120x+64); scoreboard vs software RS model, random m_ready backpressure.
//  1) 64 zero symbols, s_last on #64 -> 64 zeros, parity 0,0,0,0, m_last on beat 68, len_err=0.
//  2) Single symbol 8'h01 with s_last -> m_data 01, then parity 15,54,120,64; m_last on 4th.
//  3) 64 symbols, no s_last -> parity after #64, len_err pulses exactly once on accept of #64.
//  4) Back-to-back codewords (lengths 1,64,17) with m_ready toggling 50% -> each parity matches
//     model, no lost/duplicated beats, m_data stable under stall, s_ready=0 during parity.
//  5) rst asserted at symbol 30 then new 8'h01,s_last codeword -> m_valid=0 cycle after rst;
//     output 01,15,54,120,64 (no residue from aborted codeword).
//  6) Re-elaborate SYM_W=8, N_PAR=16, FCR=1, K_MAX=239 -> random codewords match model.

Source files
------------

// File: rtl/rs_encoder_stream.sv
// Streaming systematic Reed-Solomon encoder over GF(2^SYM_W).
// Message symbols pass through; N_PAR parity symbols follow, highest degree first.
module rs_encoder_stream #(
    parameter int               SYM_W = 8,
    parameter logic [SYM_W-1:0] PRIM  = 8'h1d,
    parameter int               K_MAX = 64,
    parameter int               N_PAR = 4,
    parameter int               FCR   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [SYM_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             m_parity,
    output logic             len_err
);

    localparam int CNT_W = $clog2(K_MAX + 1);
    localparam int IDX_W = (N_PAR > 1) ? $clog2(N_PAR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PAR - 1);

    // Shift-and-add multiply, reduced by the primitive polynomial each step.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < SYM_W; k++) begin
            if (b[k]) p = p ^ x;
            x = x[SYM_W-1] ? ((x << 1) ^ PRIM) : (x << 1);
        end
        return p;
    endfunction

    // g(x) = prod (x + a^(FCR+i)); the monic top coefficient is implicit.
    function automatic logic [N_PAR*SYM_W-1:0] gen_poly();
        logic [SYM_W-1:0]       c [N_PAR+1];
        logic [SYM_W-1:0]       root;
        logic [N_PAR*SYM_W-1:0] packed_g;
        for (int j = 0; j <= N_PAR; j++) c[j] = '0;
        c[0] = SYM_W'(1);
        root = SYM_W'(1);
        for (int j = 0; j < FCR; j++) root = gf_mul(root, SYM_W'(2));
        for (int i = 0; i < N_PAR; i++) begin
            for (int j = i + 1; j >= 1; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
            c[0] = gf_mul(c[0], root);
            root = gf_mul(root, SYM_W'(2));
        end
        packed_g = '0;
        for (int j = 0; j < N_PAR; j++) packed_g[j*SYM_W +: SYM_W] = c[j];
        return packed_g;
    endfunction

    localparam logic [N_PAR*SYM_W-1:0] G = gen_poly();

    typedef enum logic {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [SYM_W-1:0] r   [N_PAR];
    logic [SYM_W-1:0] r_n [N_PAR];
    logic [CNT_W-1:0] count, count_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [SYM_W-1:0] data_n;
    logic             valid_n, last_n, parity_n, len_err_n;
    logic [SYM_W-1:0] fb;
    logic             load_ok, accept;

    // Handshake: a beat moves on either side only in a cycle where valid && ready.
    assign load_ok = !m_valid || m_ready;
    assign s_ready = (state == ST_MSG) && load_ok;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_MSG;
            count    <= '0;
            idx      <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_parity <= 1'b0;
            len_err  <= 1'b0;
            for (int i = 0; i < N_PAR; i++) r[i] <= '0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            idx      <= idx_n;
            m_data   <= data_n;
            m_valid  <= valid_n;
            m_last   <= last_n;
            m_parity <= parity_n;
            len_err  <= len_err_n;
            for (int i = 0; i < N_PAR; i++) r[i] <= r_n[i];
        end
    end

    always_comb begin
        state_n   = state;
        r_n       = r;
        count_n   = count;
        idx_n     = idx;
        data_n    = m_data;
        valid_n   = m_valid && !m_ready;
        last_n    = m_last;
        parity_n  = m_parity;
        len_err_n = 1'b0;
        fb        = '0;

        if (accept) begin
            fb     = s_data ^ r[N_PAR-1];
            r_n[0] = gf_mul(G[0 +: SYM_W], fb);
            for (int i = 1; i < N_PAR; i++)
                r_n[i] = r[i-1] ^ gf_mul(G[i*SYM_W +: SYM_W], fb);
            count_n  = count + 1'b1;
            data_n   = s_data;
            valid_n  = 1'b1;
            parity_n = 1'b0;
            last_n   = 1'b0;
            if (s_last || count == CNT_LAST) begin
                state_n   = ST_PAR;
                idx_n     = '0;
                len_err_n = (count == CNT_LAST) && !s_last;
            end
        end else if (state == ST_PAR && load_ok) begin
            // Shifting zeros in leaves the LFSR clear once the last parity leaves.
            data_n = r[N_PAR-1];
            r_n[0] = '0;
            for (int i = 1; i < N_PAR; i++) r_n[i] = r[i-1];
            valid_n  = 1'b1;
            parity_n = 1'b1;
            idx_n    = idx + 1'b1;
            last_n   = 1'b0;
            if (idx == IDX_LAST) begin
                last_n  = 1'b1;
                count_n = '0;
                idx_n   = '0;
                state_n = ST_MSG;
            end
        end
    end

endmodule
